alu_rr_arbiter: RTL and testbench

Round-robin arbiter that shares one `alu_4bit` instance among `NREQ` requesters. Each requester presents an operation (A, B, ALU_Sel) under a valid/ready handshake. The arbiter grants one request per cycle, latches the ALU result into a single-entry output register, and returns it tagged with the requester index under a valid/ready response handshake. It sits between the block's clients and the shared ALU datapath.

---
 rtl/alu_pkg.sv | 29 ++
 rtl/alu_4bit.sv | 48 ++++
 rtl/alu_rr_arbiter.sv | 163 ++++++++++++++++
 tb/tb_alu_rr_arbiter.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the 4-bit ALU and the round-robin arbiter that
// fronts it.
//   ALU_W        : operand / result width of the ALU datapath
//   alu_sel_e    : ALU_Sel operation encodings
//   rsp_state_e  : occupancy of the single-entry response register
// ---------------------------------------------------------------------------
package alu_pkg;

    localparam int ALU_W = 4;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_XOR = 3'b100,
        ALU_NOT = 3'b101,
        ALU_SHL = 3'b110,
        ALU_SHR = 3'b111
    } alu_sel_e;

    typedef enum logic {
        RSP_EMPTY = 1'b0,
        RSP_FULL  = 1'b1
    } rsp_state_e;

endpackage

// File: rtl/alu_4bit.sv
// ---------------------------------------------------------------------------
// alu_4bit
// Purely combinational 4-bit ALU.
//   a, b      in  ALU_W : operands
//   alu_sel   in  3     : operation (alu_sel_e encoding)
//   alu_out   out ALU_W : result
//   carry_out out 1     : add carry / subtract borrow; 0 for logic and shifts
// ---------------------------------------------------------------------------
module alu_4bit
    import alu_pkg::*;
(
    input  logic [ALU_W-1:0] a,
    input  logic [ALU_W-1:0] b,
    input  logic [2:0]       alu_sel,
    output logic [ALU_W-1:0] alu_out,
    output logic             carry_out
);

    logic [ALU_W:0] sum;
    logic [ALU_W:0] diff;

    // One extra bit so the carry (or borrow, for subtraction) falls out as the MSB.
    assign sum  = {1'b0, a} + {1'b0, b};
    assign diff = {1'b0, a} - {1'b0, b};

    always_comb begin
        alu_out   = '0;
        carry_out = 1'b0;
        case (alu_sel)
            ALU_ADD: begin
                alu_out   = sum[ALU_W-1:0];
                carry_out = sum[ALU_W];
            end
            ALU_SUB: begin
                alu_out   = diff[ALU_W-1:0];
                carry_out = diff[ALU_W];
            end
            ALU_AND: alu_out = a & b;
            ALU_OR:  alu_out = a | b;
            ALU_XOR: alu_out = a ^ b;
            ALU_NOT: alu_out = ~a;
            ALU_SHL: alu_out = {a[ALU_W-2:0], 1'b0};
            ALU_SHR: alu_out = {1'b0, a[ALU_W-1:1]};
            default: ;
        endcase
    end

endmodule

// File: rtl/alu_rr_arbiter.sv
// ---------------------------------------------------------------------------
// alu_rr_arbiter
// Shares one alu_4bit among NREQ requesters with round-robin priority and a
// single-entry registered response.
//   clk, rst_n  in  : clock, synchronous active-low reset
//   req_valid   in  NREQ     : requester i presents an operation
//   req_ready   out NREQ     : one-hot grant (combinational)
//   req_a/b     in  4*NREQ   : operands, requester i at [4i+3:4i]
//   req_sel     in  3*NREQ   : ALU_Sel, requester i at [3i+2:3i]
//   rsp_valid   out 1        : response register holds a result
//   rsp_ready   in  1        : consumer accepts the result
//   rsp_id      out IDW      : requester index of the held result
//   rsp_out     out 4        : registered ALU result
//   rsp_carry   out 1        : registered carry/borrow
//   op_count    out 16       : accepted-operation counter, wrapping
// ---------------------------------------------------------------------------
module alu_rr_arbiter
    import alu_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [ALU_W*NREQ-1:0]   req_a,
    input  logic [ALU_W*NREQ-1:0]   req_b,
    input  logic [3*NREQ-1:0]       req_sel,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [IDW-1:0]          rsp_id,
    output logic [ALU_W-1:0]        rsp_out,
    output logic                    rsp_carry,
    output logic [15:0]             op_count
);

    rsp_state_e         state_reg, state_next;
    logic [IDW-1:0]     ptr_reg, ptr_next;
    logic [IDW-1:0]     id_reg, id_next;
    logic [ALU_W-1:0]   out_reg, out_next;
    logic               carry_reg, carry_next;
    logic [15:0]        count_reg, count_next;

    logic [ALU_W-1:0]   a_arr   [NREQ];
    logic [ALU_W-1:0]   b_arr   [NREQ];
    logic [2:0]         sel_arr [NREQ];
    logic [NREQ-1:0]    upper_mask;
    logic [NREQ-1:0]    upper_req;

    logic               can_accept;
    logic               grant_valid;
    logic [IDW-1:0]     grant_idx;
    logic [NREQ-1:0]    grant_onehot;

    logic [ALU_W-1:0]   alu_a, alu_b, alu_res;
    logic [2:0]         alu_sel;
    logic               alu_carry;

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_req
            assign a_arr[gi]      = req_a[ALU_W*gi +: ALU_W];
            assign b_arr[gi]      = req_b[ALU_W*gi +: ALU_W];
            assign sel_arr[gi]    = req_sel[3*gi +: 3];
            // Requesters at or above the pointer get first look.
            assign upper_mask[gi] = (IDW'(gi) >= ptr_reg);
        end
    endgenerate

    assign upper_req = req_valid & upper_mask;

    // A drain in this cycle frees the slot immediately, giving 1 op/cycle.
    // Held low during reset so no requester sees a grant.
    assign can_accept = rst_n && ((state_reg == RSP_EMPTY) || rsp_ready);

    // Wrapped priority search: lowest valid index at/above ptr, otherwise
    // lowest valid index overall.
    always_comb begin : rr_search
        grant_valid  = 1'b0;
        grant_idx    = '0;
        grant_onehot = '0;
        alu_a        = '0;
        alu_b        = '0;
        alu_sel      = '0;
        if (can_accept) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!grant_valid && upper_req[i]) begin
                    grant_valid = 1'b1;
                    grant_idx   = IDW'(i);
                end
            end
            for (int i = 0; i < NREQ; i++) begin
                if (!grant_valid && req_valid[i]) begin
                    grant_valid = 1'b1;
                    grant_idx   = IDW'(i);
                end
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (grant_valid && (grant_idx == IDW'(i))) begin
                grant_onehot[i] = 1'b1;
                alu_a           = a_arr[i];
                alu_b           = b_arr[i];
                alu_sel         = sel_arr[i];
            end
        end
    end

    assign req_ready = grant_onehot;

    alu_4bit u_alu (
        .a         (alu_a),
        .b         (alu_b),
        .alu_sel   (alu_sel),
        .alu_out   (alu_res),
        .carry_out (alu_carry)
    );

    always_comb begin : next_state
        state_next = state_reg;
        ptr_next   = ptr_reg;
        id_next    = id_reg;
        out_next   = out_reg;
        carry_next = carry_reg;
        count_next = count_reg;
        if (grant_valid) begin
            state_next = RSP_FULL;
            out_next   = alu_res;
            carry_next = alu_carry;
            id_next    = grant_idx;
            ptr_next   = (grant_idx == IDW'(NREQ-1)) ? '0 : grant_idx + IDW'(1);
            count_next = count_reg + 16'd1;
        end else if ((state_reg == RSP_FULL) && rsp_ready) begin
            state_next = RSP_EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= RSP_EMPTY;
            ptr_reg   <= '0;
            id_reg    <= '0;
            out_reg   <= '0;
            carry_reg <= 1'b0;
            count_reg <= '0;
        end else begin
            state_reg <= state_next;
            ptr_reg   <= ptr_next;
            id_reg    <= id_next;
            out_reg   <= out_next;
            carry_reg <= carry_next;
            count_reg <= count_next;
        end
    end

    assign rsp_valid = (state_reg == RSP_FULL);
    assign rsp_id    = id_reg;
    assign rsp_out   = out_reg;
    assign rsp_carry = carry_reg;
    assign op_count  = count_reg;

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_alu_rr_arbiter
// Directed steps followed by random traffic, every cycle checked against a
// behavioural model of the arbiter (round-robin search by modular offset,
// ALU by plain integer arithmetic).
// ---------------------------------------------------------------------------
module tb_alu_rr_arbiter;

    localparam int NREQ = 4;
    localparam int IDW  = 3;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [4*NREQ-1:0]  req_a;
    logic [4*NREQ-1:0]  req_b;
    logic [3*NREQ-1:0]  req_sel;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [IDW-1:0]     rsp_id;
    logic [3:0]         rsp_out;
    logic               rsp_carry;
    logic [15:0]        op_count;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model state
    bit          m_full;
    int          m_ptr;
    logic [3:0]  m_out;
    logic        m_carry;
    logic [2:0]  m_id;
    logic [15:0] m_cnt;

    logic [NREQ-1:0] obs_rdy;   // req_ready observed in the last cycle
    logic [3:0]      held_out;
    logic [2:0]      held_id;
    logic            held_carry;

    always #5 clk = ~clk;

    alu_rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_sel   (req_sel),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_out   (rsp_out),
        .rsp_carry (rsp_carry),
        .op_count  (op_count)
    );

    function automatic void alu_ref(input int a, input int b, input int sel,
                                    output logic [3:0] o, output logic c);
        int r;
        r = 0;
        c = 1'b0;
        case (sel)
            0: begin r = a + b;             c = (a + b) > 15; end
            1: begin r = (a - b + 16) % 16; c = (a < b);      end
            2: r = a & b;
            3: r = a | b;
            4: r = a ^ b;
            5: r = 15 - a;
            6: r = (a * 2) % 16;
            default: r = a / 2;
        endcase
        o = 4'(r);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_op(input int i, input int a, input int b, input int s);
        req_a[4*i +: 4] = 4'(a);
        req_b[4*i +: 4] = 4'(b);
        req_sel[3*i +: 3] = 3'(s);
    endtask

    // One clock cycle: inputs already driven; check grant at the falling
    // edge, advance the model at the rising edge, check outputs 1 ns later.
    task automatic do_cycle(input bit verbose);
        int g;
        int idx;
        logic [NREQ-1:0] exp_rdy;
        logic [3:0] eo;
        logic ec;
        @(negedge clk);
        g = -1;
        exp_rdy = '0;
        eo = '0;
        ec = 1'b0;
        if (rst_n && (!m_full || rsp_ready)) begin
            for (int k = 0; k < NREQ; k++) begin
                idx = (m_ptr + k) % NREQ;
                if (g < 0 && req_valid[idx]) g = idx;
            end
        end
        if (g >= 0) begin
            exp_rdy[g] = 1'b1;
            alu_ref(int'(req_a[4*g +: 4]), int'(req_b[4*g +: 4]), int'(req_sel[3*g +: 3]), eo, ec);
        end
        obs_rdy = req_ready;
        check("req_ready", 32'(req_ready), 32'(exp_rdy));
        @(posedge clk);
        if (!rst_n) begin
            m_full = 0; m_ptr = 0; m_out = '0; m_carry = 1'b0; m_id = '0; m_cnt = '0;
        end else if (g >= 0) begin
            m_full = 1; m_out = eo; m_carry = ec; m_id = 3'(g);
            m_ptr = (g + 1) % NREQ; m_cnt = m_cnt + 16'd1;
        end else if (m_full && rsp_ready) begin
            m_full = 0;
        end
        #1;
        check("rsp_valid", 32'(rsp_valid), 32'(m_full));
        check("rsp_out",   32'(rsp_out),   32'(m_out));
        check("rsp_carry", 32'(rsp_carry), 32'(m_carry));
        check("rsp_id",    32'(rsp_id),    32'(m_id));
        check("op_count",  32'(op_count),  32'(m_cnt));
        if (verbose)
            $display("t=%0t rst_n=%b valid=%b rdy=%b grant=%0d | rsp_valid=%b id=%0d out=%h carry=%b cnt=%0d",
                     $time, rst_n, req_valid, obs_rdy, g, rsp_valid, rsp_id, rsp_out, rsp_carry, op_count);
    endtask

    initial begin
        m_full = 0; m_ptr = 0; m_out = '0; m_carry = 1'b0; m_id = '0; m_cnt = '0;
        rst_n = 1'b0; req_valid = '0; req_a = '0; req_b = '0; req_sel = '0; rsp_ready = 1'b0;
        #1;

        // Reset then idle
        do_cycle(1);
        do_cycle(1);
        rst_n = 1'b1;
        do_cycle(1);
        check("idle_rsp_valid", 32'(rsp_valid), 32'd0);
        check("idle_op_count",  32'(op_count),  32'd0);
        check("idle_req_ready", 32'(req_ready), 32'd0);

        // Single add with carry: 9+8 = 17 -> out 1, carry 1
        rsp_ready = 1'b1;
        req_valid = 4'b0100;
        set_op(2, 9, 8, 0);
        do_cycle(1);
        check("add_grant", 32'(obs_rdy),   32'b0100);
        check("add_valid", 32'(rsp_valid), 32'd1);
        check("add_id",    32'(rsp_id),    32'd2);
        check("add_out",   32'(rsp_out),   32'd1);
        check("add_carry", 32'(rsp_carry), 32'd1);

        // Subtract with borrow: 3-5 -> E, borrow
        req_valid = 4'b0001;
        set_op(0, 3, 5, 1);
        do_cycle(1);
        check("sub_out",   32'(rsp_out),   32'hE);
        check("sub_carry", 32'(rsp_carry), 32'd1);
        // SHL 1001 -> 0010, carry 0
        set_op(0, 9, 0, 6);
        do_cycle(1);
        check("shl_out",   32'(rsp_out),   32'h2);
        check("shl_carry", 32'(rsp_carry), 32'd0);

        // Round-robin fairness from a fresh reset
        req_valid = '0;
        rst_n = 1'b0;
        do_cycle(1);
        rst_n = 1'b1;
        req_valid = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            req_a = 16'($urandom); req_b = 16'($urandom); req_sel = 12'($urandom);
            do_cycle(1);
            check("rr_order", 32'(obs_rdy), 32'(1 << (k % 4)));
            check("rr_valid", 32'(rsp_valid), 32'd1);
        end
        check("rr_count", 32'(op_count), 32'd8);

        // Backpressure: FULL, rsp_ready low, requesters 1 and 3 valid
        rsp_ready = 1'b0;
        req_valid = 4'b1010;
        held_out = rsp_out; held_id = rsp_id; held_carry = rsp_carry;
        for (int k = 0; k < 3; k++) begin
            req_a = 16'($urandom); req_b = 16'($urandom); req_sel = 12'($urandom);
            do_cycle(1);
            check("bp_no_ready", 32'(obs_rdy),   32'd0);
            check("bp_out_hold", 32'(rsp_out),   32'(held_out));
            check("bp_id_hold",  32'(rsp_id),    32'(held_id));
            check("bp_cy_hold",  32'(rsp_carry), 32'(held_carry));
        end
        rsp_ready = 1'b1;
        do_cycle(1);
        check("bp_drain_grant", 32'(obs_rdy),   32'b0010);
        check("bp_valid_stays", 32'(rsp_valid), 32'd1);
        check("bp_new_id",      32'(rsp_id),    32'd1);

        // Mid-operation reset drops the held result and resets ptr
        rsp_ready = 1'b0;
        rst_n = 1'b0;
        do_cycle(1);
        check("mid_rst_valid", 32'(rsp_valid), 32'd0);
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        req_valid = 4'b1111;
        do_cycle(1);
        check("mid_rst_ptr0", 32'(obs_rdy), 32'b0001);

        // Random traffic with occasional reset
        for (int k = 0; k < 300; k++) begin
            rst_n     = ($urandom_range(0, 49) != 0);
            req_valid = 4'($urandom);
            rsp_ready = ($urandom_range(0, 3) != 0);
            req_a = 16'($urandom); req_b = 16'($urandom); req_sel = 12'($urandom);
            do_cycle(1);
        end

        // Counter wrap after 65536 accepts
        rst_n = 1'b0;
        do_cycle(1);
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        req_valid = 4'b0001;
        for (int k = 0; k < 65535; k++) do_cycle(0);
        check("cnt_ffff", 32'(op_count), 32'hFFFF);
        do_cycle(1);
        check("cnt_wrap", 32'(op_count), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
